// File: rtl/stream_accumulator.sv
// Frame accumulator: sums COUNT n-bit operands through a carry-lookahead adder and
// holds the result with a sticky carry flag. Define STREAM_ACCUMULATOR_SATURATE_EN to saturate.

module nBitCarryLookAheadAdder #(
    parameter int unsigned n = 4
) (
    input  logic [n-1:0] a,
    input  logic [n-1:0] b,
    output logic [n:0]   total
);

    logic [n-1:0] gen;
    logic [n-1:0] prop;
    logic [n:0]   carry;
    logic         chain;

    assign gen  = a & b;
    assign prop = a ^ b;

    // Each carry is expanded from generate/propagate terms only, no ripple dependency.
    always_comb begin
        carry    = '0;
        chain    = 1'b0;
        carry[0] = 1'b0;
        for (int i = 0; i < int'(n); i++) begin
            carry[i+1] = gen[i];
            chain      = prop[i];
            for (int j = i - 1; j >= 0; j--) begin
                carry[i+1] = carry[i+1] | (chain & gen[j]);
                chain      = chain & prop[j];
            end
        end
    end

    assign total = {carry[n], prop ^ carry[n-1:0]};

endmodule

module stream_accumulator #(
    parameter int unsigned n     = 4,
    parameter int unsigned COUNT = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         in_valid,
    input  logic [n-1:0] in_data,
    output logic         in_ready,
    output logic         out_valid,
    output logic [n-1:0] out_data,
    output logic         out_overflow,
    input  logic         out_ready,
    output logic         busy
);

    localparam int unsigned CNT_W = $clog2(COUNT + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [n-1:0]     acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic [n:0]       total;
    logic             xfer;

    nBitCarryLookAheadAdder #(
        .n(n)
    ) u_add (
        .a    (acc_q),
        .b    (in_data),
        .total(total)
    );

    assign xfer = in_valid & in_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = ACC;
                    acc_d   = '0;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                end
            end
            ACC: begin
                if (xfer) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    ovf_d = ovf_q | total[n];
`ifdef STREAM_ACCUMULATOR_SATURATE_EN
                    // Once any carry is seen the sum stays pinned at all-ones.
                    acc_d = (total[n] | ovf_q) ? {n{1'b1}} : total[n-1:0];
`else
                    acc_d = total[n-1:0];
`endif
                    if (cnt_q == CNT_W'(COUNT - 1)) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs decode directly from registered state; result is masked outside DONE.
    assign in_ready     = (state_q == ACC);
    assign out_valid    = (state_q == DONE);
    assign busy         = (state_q != IDLE);
    assign out_data     = out_valid ? acc_q : '0;
    assign out_overflow = out_valid & ovf_q;

endmodule

// File: tb/tb_stream_accumulator.sv
// Randomized/directed bench for stream_accumulator (n=4, COUNT=4 and COUNT=1 instances)
// against a frame-sum reference model.

module tb_stream_accumulator;

    localparam int unsigned N   = 4;
    localparam int unsigned CNT = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start, in_valid, out_ready;
    logic [N-1:0] in_data;
    logic         in_ready, out_valid, out_overflow, busy;
    logic [N-1:0] out_data;

    logic         start1, in_valid1, out_ready1;
    logic [N-1:0] in_data1;
    logic         in_ready1, out_valid1, out_overflow1, busy1;
    logic [N-1:0] out_data1;

    int vectors    = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    stream_accumulator #(.n(N), .COUNT(CNT)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_overflow(out_overflow),
        .out_ready   (out_ready),
        .busy        (busy)
    );

    stream_accumulator #(.n(N), .COUNT(1)) dut1 (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start1),
        .in_valid    (in_valid1),
        .in_data     (in_data1),
        .in_ready    (in_ready1),
        .out_valid   (out_valid1),
        .out_data    (out_data1),
        .out_overflow(out_overflow1),
        .out_ready   (out_ready1),
        .busy        (busy1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: the frame result depends only on the arithmetic total of its operands.
    function automatic int model_data(input int sum);
`ifdef STREAM_ACCUMULATOR_SATURATE_EN
        return (sum >= (1 << N)) ? ((1 << N) - 1) : sum;
`else
        return sum % (1 << N);
`endif
    endfunction

    function automatic int model_ovf(input int sum);
        return (sum >= (1 << N)) ? 1 : 0;
    endfunction

    task automatic step();
        @(negedge clk);
    endtask

    task automatic run_frame(input int v[CNT], input int gap_min, input int gap_max,
                             input int bp, input bit poke_start);
        int sum = 0;
        int gaps;
        start    = 1'b1;
        in_valid = 1'($urandom_range(0, 1));
        in_data  = N'($urandom_range(0, 15));
        chk("idle_in_ready", in_ready, 0);
        step();
        start = 1'b0;
        for (int i = 0; i < int'(CNT); i++) begin
            gaps = $urandom_range(gap_min, gap_max);
            for (int g = 0; g < gaps; g++) begin
                in_valid  = 1'b0;
                in_data   = N'($urandom_range(0, 15));
                start     = 1'($urandom_range(0, 1));
                out_ready = 1'($urandom_range(0, 1));
                step();
                chk("gap_busy", busy, 1);
                chk("gap_out_valid", out_valid, 0);
                chk("gap_out_data", out_data, 0);
            end
            in_valid = 1'b1;
            in_data  = N'(v[i]);
            sum += v[i];
            chk("acc_in_ready", in_ready, 1);
            chk("acc_out_valid", out_valid, 0);
            step();
        end
        in_valid = 1'($urandom_range(0, 1));
        in_data  = N'($urandom_range(0, 15));
        start    = 1'b0;
        chk("done_out_valid", out_valid, 1);
        chk("done_out_data", out_data, model_data(sum));
        chk("done_out_overflow", out_overflow, model_ovf(sum));
        chk("done_in_ready", in_ready, 0);
        chk("done_busy", busy, 1);
        for (int b = 0; b < bp; b++) begin
            out_ready = 1'b0;
            start     = poke_start;
            step();
            chk("bp_out_valid", out_valid, 1);
            chk("bp_out_data", out_data, model_data(sum));
            chk("bp_out_overflow", out_overflow, model_ovf(sum));
            chk("bp_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        start     = 1'b0;
        step();
        chk("post_out_valid", out_valid, 0);
        chk("post_out_data", out_data, 0);
        chk("post_out_overflow", out_overflow, 0);
        chk("post_busy", busy, 0);
        out_ready = 1'b0;
        in_valid  = 1'b0;
        step();
        chk("idle_stays", busy, 0);
    endtask

    initial begin
        int v[CNT];
        rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        start1 = 1'b0; in_valid1 = 1'b0; in_data1 = '0; out_ready1 = 1'b0;
        step();
        start = 1'b1;
        step();
        rst_n = 1'b1;
        start = 1'b0;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_overflow", out_overflow, 0);
        chk("rst1_busy", busy1, 0);
        step();
        chk("rst_start_ignored", busy, 0);

        v = '{1, 2, 3, 4};
        run_frame(v, 0, 0, 0, 1'b0);
        v = '{15, 1, 0, 0};
        run_frame(v, 0, 0, 0, 1'b0);
        v = '{1, 2, 3, 4};
        run_frame(v, 3, 3, 0, 1'b0);
        v = '{5, 6, 7, 8};
        run_frame(v, 0, 1, 5, 1'b1);

        // Reset in the middle of a frame discards the partial sum.
        start = 1'b1;
        step();
        start = 1'b0;
        in_valid = 1'b1; in_data = 4'd1;
        step();
        step();
        rst_n = 1'b0; start = 1'b1; in_valid = 1'b1;
        step();
        rst_n = 1'b1; start = 1'b0; in_valid = 1'b0;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_in_ready", in_ready, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_out_data", out_data, 0);
        chk("midrst_out_overflow", out_overflow, 0);
        step();
        chk("midrst_idle", busy, 0);
        v = '{1, 1, 1, 1};
        run_frame(v, 0, 0, 0, 1'b0);

        for (int f = 0; f < 40; f++) begin
            for (int i = 0; i < int'(CNT); i++) v[i] = $urandom_range(0, 15);
            run_frame(v, 0, $urandom_range(0, 3), $urandom_range(0, 4), 1'($urandom_range(0, 1)));
        end

        // Single-operand frames on the COUNT=1 instance.
        for (int k = 0; k < 4; k++) begin
            int d;
            d = (k == 0) ? 9 : $urandom_range(0, 15);
            start1 = 1'b1;
            step();
            start1 = 1'b0;
            in_valid1 = 1'b1;
            in_data1  = N'(d);
            chk("c1_in_ready", in_ready1, 1);
            step();
            in_valid1 = 1'b0;
            chk("c1_out_valid", out_valid1, 1);
            chk("c1_out_data", out_data1, d);
            chk("c1_out_overflow", out_overflow1, 0);
            out_ready1 = 1'b1;
            step();
            out_ready1 = 1'b0;
            chk("c1_post_valid", out_valid1, 0);
            chk("c1_post_busy", busy1, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
